cache_miss_ctrl: RTL

Lookup sequencer and victim-selection controller for the 4-way, 8-set tag store.
- Upstream: accepts one tag/index request at a time and drives the tag store's `tag`, `index`, `way` and `replace` inputs.
- Downstream: consumes the store's `iHit`, `wayOut` and `validComp` outputs.
- Each set keeps a tree pseudo-LRU. On a miss the block runs a single outstanding refill handshake with memory, then writes the victim way.

---
 rtl/cache_miss_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cache_miss_ctrl.sv
// Lookup sequencer and victim selector for a 4-way tag store with per-set tree pseudo-LRU.
// Runs one outstanding refill at a time: lookup, memory request, wait for fill, write victim.
module cache_miss_ctrl #(
  parameter int TAG_W = 24,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [IDX_W-1:0]   req_index,
  output logic [TAG_W-1:0]   tag,
  output logic [IDX_W-1:0]   index,
  output logic [1:0]         way,
  output logic               replace,
  input  logic               iHit,
  input  logic [1:0]         wayOut,
  input  logic [3:0]         validComp,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr,
  input  logic               mem_fill_valid,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [1:0]         resp_way
);

  localparam int SETS = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    WAIT_FILL = 3'd3,
    REFILL    = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [TAG_W-1:0]           tag_q, tag_d;
  logic [IDX_W-1:0]           index_q, index_d;
  logic [1:0]                 way_q, way_d;
  logic [1:0]                 victim_q, victim_d;
  logic [SETS-1:0][2:0]       plru_q, plru_d;

  // Tree bits {b2,b1,b0}: b0 picks the half to evict, b1/b2 pick the way inside it.
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r = b;
    if (!w[1]) begin
      r[0] = 1'b1;
      r[1] = ~w[0];
    end else begin
      r[0] = 1'b0;
      r[2] = ~w[0];
    end
    return r;
  endfunction

  function automatic logic [1:0] first_invalid(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) r = 2'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    way_d    = way_q;
    victim_d = victim_q;
    plru_d   = plru_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          tag_d   = req_tag;
          index_d = req_index;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (iHit) begin
          plru_d[index_q] = plru_touch(plru_q[index_q], wayOut);
          state_d         = IDLE;
        end else begin
          victim_d = (&validComp) ? plru_victim(plru_q[index_q]) : first_invalid(validComp);
          state_d  = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (mem_req_ready) state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (mem_fill_valid) begin
          way_d   = victim_q;
          state_d = REFILL;
        end
      end
      REFILL: begin
        plru_d[index_q] = plru_touch(plru_q[index_q], victim_q);
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      way_q    <= '0;
      victim_q <= '0;
      plru_q   <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      way_q    <= way_d;
      victim_q <= victim_d;
      plru_q   <= plru_d;
    end
  end

  // Strobes are decoded from state so the hit response lands in the LOOKUP cycle itself.
  assign req_ready     = (state_q == IDLE);
  assign mem_req_valid = (state_q == MISS_REQ);
  assign replace       = (state_q == REFILL);
  assign resp_valid    = ((state_q == LOOKUP) && iHit) || (state_q == REFILL);
  assign resp_hit      = (state_q == LOOKUP);
  assign resp_way      = (state_q == LOOKUP) ? wayOut : victim_q;
  assign mem_req_addr  = {tag_q, index_q};
  assign tag           = tag_q;
  assign index         = index_q;
  assign way           = way_q;

endmodule
